// File: rtl/fir_decim_buffer_if.sv
// fir_decim_buffer_if: sample input and valid/ready output stream of the
// FIR decimating output buffer. The slave modport is the buffer's view and
// the master modport is the view of the logic that drives and drains it.
interface fir_decim_buffer_if #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16,
    parameter int DEPTH = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                    ready;        // shared filter enable
    logic signed [IN_W-1:0]  filtred_sig;  // filter result, stable between events
    logic                    out_valid;    // FIFO head is valid
    logic                    out_ready;    // consumer takes the head this cycle
    logic signed [OUT_W-1:0] out_data;     // FIFO head (first-word fall-through)
    logic [LVL_W-1:0]        level;        // FIFO occupancy
    logic                    overflow;     // sticky drop flag

    modport slave (
        input  ready, filtred_sig, out_ready,
        output out_valid, out_data, level, overflow
    );

    modport master (
        output ready, filtred_sig, out_ready,
        input  out_valid, out_data, level, overflow
    );
endinterface

// File: rtl/fir_decim_buffer.sv
// fir_decim_buffer: follows the 128-cycle frame of the serial FIR filter,
// captures each new result, keeps every DECIM-th one, narrows it to OUT_W
// bits and queues it in a DEPTH-entry first-word-fall-through FIFO.
// Optional feature macro: FIR_DECIM_SAT_EN (saturate instead of truncate).
module fir_decim_buffer #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16,
    parameter int DECIM = 1,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_decim_buffer_if.slave    bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

    logic [6:0]              r_phase;     // mirrors the filter's read index
    logic                    r_pend;      // new filter result is on filtred_sig
    logic                    r_primed;    // first (empty-frame) event consumed
    logic [DCNT_W-1:0]       r_dcnt;      // decimation position of next capture
    logic signed [OUT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [LVL_W-1:0]        r_level;
    logic                    r_overflow;

    logic                    w_event;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_wr_en;
    logic signed [OUT_W-1:0] w_narrow;

    // An update event is the last tap of a frame; the filter loads its result on that edge.
    assign w_event = bus.ready && (r_phase == 7'd127);
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);
    assign w_pop   = !w_empty && bus.out_ready;
    assign w_push  = r_pend && r_primed && (r_dcnt == '0);
    // A full FIFO still accepts the push when the head leaves on the same edge.
    assign w_wr_en = w_push && (!w_full || w_pop);

    // Frame phase tracking and capture strobe; pend is deliberately not gated by ready.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values.
        if (rst) begin
            r_phase <= 7'd127;
            r_pend  <= 1'b0;
        end else begin
            if (bus.ready) begin
                r_phase <= r_phase + 7'd1;
            end
            r_pend <= w_event;
        end
    end

    // First-event discard and decimation counter, advanced once per kept event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_primed <= 1'b0;
            r_dcnt   <= '0;
        end else if (r_pend) begin
            if (!r_primed) begin
                r_primed <= 1'b1;
            end else begin
                r_dcnt <= (r_dcnt == DCNT_LAST) ? '0 : r_dcnt + DCNT_ONE;
            end
        end
    end

`ifdef FIR_DECIM_SAT_EN
    localparam int SAT_MAX_I = (2 ** (OUT_W - 1)) - 1;
    localparam int SAT_MIN_I = -(2 ** (OUT_W - 1));
    localparam logic signed [IN_W-1:0] SAT_HI = IN_W'(SAT_MAX_I);
    localparam logic signed [IN_W-1:0] SAT_LO = IN_W'(SAT_MIN_I);

    // Narrow with saturation to the signed OUT_W range.
    always_comb begin
        // NOTE: default assigned first so every path drives w_narrow and no latch forms.
        w_narrow = bus.filtred_sig[OUT_W-1:0];
        if (bus.filtred_sig > SAT_HI) begin
            w_narrow = OUT_W'(SAT_MAX_I);
        end else if (bus.filtred_sig < SAT_LO) begin
            w_narrow = OUT_W'(SAT_MIN_I);
        end
    end
`else
    // Narrow by plain truncation; out-of-range values wrap.
    always_comb begin
        w_narrow = bus.filtred_sig[OUT_W-1:0];
    end

    if (IN_W > OUT_W) begin : g_drop_msbs
        logic w_unused_msbs;
        assign w_unused_msbs = ^bus.filtred_sig[IN_W-1:OUT_W];
    end
`endif

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; out_data is forced to zero while empty so stale words never show.
        if (!rst && w_wr_en) begin
            r_mem[r_wr_ptr] <= w_narrow;
        end
    end

    // FIFO pointers, occupancy and sticky overflow; reset flushes queued data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_push && !w_wr_en) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_fir_decim_buffer.sv
// tb_fir_decim_buffer: directed sequence with randomized data and ready
// patterns, compared every cycle against a queue-based reference model
// that works from ready counts and event numbers.
module tb_fir_decim_buffer;
    localparam int IN_W  = 18;
    localparam int OUT_W = 16;
    localparam int DECIM = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fir_decim_buffer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

    fir_decim_buffer #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .DECIM(DECIM),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int mq[$];          // expected FIFO contents, head first
    int n_ready;        // ready cycles since reset
    int n_ev;           // update events since reset
    bit m_event;        // an event happened on the last edge
    bit m_pend_push;    // the capture following that event is a kept sample
    bit m_ovf;

    // Filter stand-in and observation
    int sig_mode;       // 0 constant, 1 stepping counter, 2 random
    int const_val;
    int sig_cnt;
    int obs_val[$];
    int obs_cyc[$];
    int cyc = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int narrow(input logic signed [IN_W-1:0] s);
        int v;
        int m;
        v = s;
        m = 2 ** OUT_W;
`ifdef FIR_DECIM_SAT_EN
        if (v > m / 2 - 1) return m / 2 - 1;
        if (v < -(m / 2)) return -(m / 2);
        return v;
`else
        v = ((v % m) + m) % m;
        if (v >= m / 2) v -= m;
        return v;
`endif
    endfunction

    function automatic int m_phase();
        return (127 + n_ready) % 128;
    endfunction

    // Reference model: one call per rising edge, using the pre-edge inputs.
    task automatic model_step();
        bit do_pop;
        if (rst) begin
            mq.delete();
            n_ready     = 0;
            n_ev        = 0;
            m_event     = 1'b0;
            m_pend_push = 1'b0;
            m_ovf       = 1'b0;
        end else begin
            do_pop = (mq.size() != 0) && bus.out_ready;
            if (do_pop) void'(mq.pop_front());
            if (m_pend_push) begin
                if (mq.size() < DEPTH) mq.push_back(narrow(bus.filtred_sig));
                else m_ovf = 1'b1;
            end
            m_event     = bus.ready && (n_ready % 128 == 0);
            m_pend_push = m_event && (n_ev >= 1) && ((n_ev - 1) % DECIM == 0);
            if (m_event) n_ev++;
            if (bus.ready) n_ready++;
        end
    endtask

    task automatic tick();
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            obs_val.push_back(int'(bus.out_data));
            obs_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        if (m_event) begin
            case (sig_mode)
                0: bus.filtred_sig = IN_W'(const_val);
                1: begin bus.filtred_sig = IN_W'(sig_cnt); sig_cnt++; end
                default: bus.filtred_sig = IN_W'($urandom);
            endcase
        end
        chk("out_valid", bus.out_valid, (mq.size() != 0) ? 1 : 0);
        chk("level", bus.level, mq.size());
        chk("overflow", bus.overflow, m_ovf ? 1 : 0);
        chk("out_data", bus.out_data, (mq.size() != 0) ? mq[0] : 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_obs(input int n, input int budget);
        int k;
        k = 0;
        while (obs_val.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("obs_timeout", (obs_val.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ready = 1'b1;
        run(2);
        rst = 1'b0;
        sig_cnt = 0;
        obs_val.delete();
        obs_cyc.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int exp_hi;
        int exp_lo;
        rst = 1'b1;
        bus.ready = 1'b0;
        bus.out_ready = 1'b0;
        bus.filtred_sig = '0;
        sig_mode = 0;
        const_val = 0;
        sig_cnt = 0;

        // Reset values
        do_reset();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_ovf", bus.overflow, 0);

        // First-frame discard with a constant filter output of 100
        sig_mode = 0;
        const_val = 100;
        bus.filtred_sig = 18'sd100;
        bus.ready = 1'b1;
        bus.out_ready = 1'b0;
        run(129);
        chk("first_before", bus.out_valid, 0);
        tick();
        chk("first_valid", bus.out_valid, 1);
        chk("first_data", bus.out_data, 100);
        chk("first_level", bus.level, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("first_popped", obs_val.size(), 1);
        if (obs_val.size() == 1) chk("first_pop_val", obs_val[0], 100);

        // Decimation by 4 of a stepping input
        do_reset();
        sig_mode = 1;
        bus.out_ready = 1'b1;
        run_until_obs(3, 2000);
        if (obs_val.size() >= 3) begin
            chk("dec_v0", obs_val[0], 1);
            chk("dec_v1", obs_val[1], 5);
            chk("dec_v2", obs_val[2], 9);
            chk("dec_gap0", obs_cyc[1] - obs_cyc[0], 512);
            chk("dec_gap1", obs_cyc[2] - obs_cyc[1], 512);
        end

        // Narrowing of out-of-range samples
`ifdef FIR_DECIM_SAT_EN
        exp_hi = 32767;
        exp_lo = -32768;
`else
        exp_hi = -25536;
        exp_lo = 25536;
`endif
        do_reset();
        sig_mode = 0;
        const_val = 40000;
        bus.filtred_sig = IN_W'(40000);
        bus.out_ready = 1'b1;
        run_until_obs(1, 400);
        const_val = -40000;
        run_until_obs(2, 800);
        if (obs_val.size() >= 2) begin
            chk("narrow_pos", obs_val[0], exp_hi);
            chk("narrow_neg", obs_val[1], exp_lo);
        end

        // Backpressure: nine kept samples into an eight-deep FIFO
        do_reset();
        sig_mode = 1;
        bus.out_ready = 1'b0;
        run(33 * 128 + 4);
        chk("ovf_level", bus.level, 8);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_head", bus.out_data, 1);
        bus.out_ready = 1'b1;
        run(12);
        chk("drain_count", obs_val.size(), 8);
        for (int i = 0; i < obs_val.size() && i < 8; i++) chk("drain_val", obs_val[i], 1 + 4 * i);
        chk("drain_ovf", bus.overflow, 1);
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_level", bus.level, 0);

        // Simultaneous push and pop while full
        do_reset();
        sig_mode = 1;
        bus.out_ready = 1'b0;
        k = 0;
        while (!(m_pend_push && n_ev == 34) && k < 5000) begin
            tick();
            k++;
        end
        chk("full_wait", (k < 5000) ? 1 : 0, 1);
        chk("full_level", bus.level, 8);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pp_level", bus.level, 8);
        chk("pp_ovf", bus.overflow, 0);
        chk("pp_head", bus.out_data, 5);
        bus.out_ready = 1'b1;
        run(12);
        chk("pp_count", obs_val.size(), 9);
        for (int i = 0; i < obs_val.size() && i < 9; i++) chk("pp_val", obs_val[i], 1 + 4 * i);
        bus.out_ready = 1'b0;

        // Gapped ready, random data, reset mid-frame with three queued
        do_reset();
        sig_mode = 2;
        bus.out_ready = 1'b0;
        k = 0;
        while (!(mq.size() == 3 && m_phase() == 60) && k < 8000) begin
            bus.ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("gap_wait", (k < 8000) ? 1 : 0, 1);
        chk("gap_level", bus.level, 3);
        rst = 1'b1;
        bus.ready = 1'($urandom_range(0, 1));
        tick();
        rst = 1'b0;
        chk("mid_rst_level", bus.level, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        k = 0;
        while (n_ev < 1 && k < 200) begin
            bus.ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        bus.ready = 1'b0;
        run(3);
        chk("post_rst_discard", bus.level, 0);
        k = 0;
        while (mq.size() < 1 && k < 1000) begin
            bus.ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("post_rst_push", bus.level, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
